imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: loads a program word-by-word into imem,
// then fetches sequentially with stall, redirect and halt-opcode handling.
module imem_fetch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        run,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  imem_addr,
  output logic        imem_we,
  output logic [15:0] imem_wdata,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [7:0]  if_pc,
  output logic        halted,
  output logic        busy_load,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  load_addr_q, load_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [7:0]  if_pc_q, if_pc_d;
  logic [15:0] count_q, count_d;
  logic        halted_q, busy_load_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      load_addr_q <= '0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
      count_q     <= '0;
      halted_q    <= 1'b0;
      busy_load_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      load_addr_q <= load_addr_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      count_q     <= count_d;
      // Status flags are registered copies of the next state so they track it exactly.
      halted_q    <= (state_d == S_HALT);
      busy_load_q <= (state_d == S_LOAD);
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    load_addr_d = load_addr_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    count_d     = count_q;
    load_ready  = 1'b0;
    imem_we     = 1'b0;
    imem_addr   = pc_q;
    imem_wdata  = '0;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (state_q == S_HALT) if_valid_d = 1'b0;
        if (load_start) begin
          state_d     = S_LOAD;
          load_addr_d = '0;
        end else if (run) begin
          state_d = S_RUN;
          pc_d    = '0;
          count_d = '0;
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        imem_addr  = load_addr_q;
        imem_we    = load_valid;
        imem_wdata = load_data;
        if (load_valid) begin
          // The top address ends the load and the pointer parks there instead of wrapping.
          if (load_last || load_addr_q == 8'hFF) state_d = S_IDLE;
          if (load_addr_q != 8'hFF) load_addr_d = load_addr_q + 8'd1;
        end
      end
      S_RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          if (imem_rdata[15:12] == 4'hF) state_d = S_HALT;
          else                           pc_d    = pc_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign halted      = halted_q;
  assign busy_load   = busy_load_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized and directed bench for imem_fetch_ctrl against a behavioural model
// of the load/fetch controller plus an attached 256x16 instruction memory.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, load_valid, load_last, load_ready;
  logic [15:0] load_data;
  logic        run, stall, redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic        imem_we;
  logic [15:0] imem_wdata, imem_rdata;
  logic        if_valid, halted, busy_load;
  logic [15:0] if_instr, instr_count;
  logic [7:0]  if_pc;

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .run(run), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .halted(halted), .busy_load(busy_load), .instr_count(instr_count)
  );

  // Environment memory driven by the DUT
  logic [15:0] env_mem [256];
  assign imem_rdata = env_mem[imem_addr];
  always @(posedge clk) if (imem_we) env_mem[imem_addr] <= imem_wdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;
  int          m_mode;
  logic [7:0]  m_pc, m_laddr, m_ipc;
  logic        m_v;
  logic [15:0] m_instr;
  int unsigned m_cnt;
  logic [15:0] m_mem [256];

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_laddr = 0; m_ipc = 0; m_v = 0; m_instr = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [15:0] w;
    case (m_mode)
      M_IDLE, M_HALT: begin
        if (m_mode == M_HALT) m_v = 0;
        if (load_start) begin m_mode = M_LOAD; m_laddr = 0; end
        else if (run) begin m_mode = M_RUN; m_pc = 0; m_cnt = 0; end
      end
      M_LOAD: if (load_valid) begin
        m_mem[m_laddr] = load_data;
        if (load_last || m_laddr == 255) m_mode = M_IDLE;
        if (m_laddr < 255) m_laddr = m_laddr + 1;
      end
      default: begin
        if (redirect_valid) begin m_pc = redirect_pc; m_v = 0; end
        else if (!stall) begin
          w = m_mem[m_pc];
          m_instr = w; m_ipc = m_pc; m_v = 1;
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
          if (w[15:12] == 4'hF) m_mode = M_HALT;
          else m_pc = 8'((int'(m_pc) + 1) % 256);
        end
      end
    endcase
  endtask

  task automatic check_comb();
    bit ld;
    ld = (m_mode == M_LOAD);
    check("load_ready", load_ready, ld);
    check("imem_we", imem_we, ld && load_valid);
    check("imem_addr", imem_addr, ld ? m_laddr : m_pc);
    check("imem_wdata", imem_wdata, ld ? load_data : 16'h0);
  endtask

  task automatic check_regs();
    check("if_valid", if_valid, m_v);
    check("if_instr", if_instr, m_instr);
    check("if_pc", if_pc, m_ipc);
    check("halted", halted, m_mode == M_HALT);
    check("busy_load", busy_load, m_mode == M_LOAD);
    check("instr_count", instr_count, m_cnt);
  endtask

  // One clock: inputs are already stable after the negedge
  task automatic cyc();
    #1;
    check_comb();
    @(posedge clk);
    model_step();
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic zero_in();
    load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
    run = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_comb();
    check_regs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic load_words(input logic [15:0] w[$], input bit with_last);
    load_start = 1; cyc(); load_start = 0;
    foreach (w[i]) begin
      load_valid = 1; load_data = w[i];
      load_last  = with_last && (i == w.size() - 1);
      cyc();
    end
    zero_in();
    cyc();
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin env_mem[i] = 16'h0; m_mem[i] = 16'h0; end
    zero_in();
    rst_n = 0;
    model_reset();
    #1;
    check("rst if_valid", if_valid, 0);
    check("rst instr_count", instr_count, 0);
    check("rst busy_load", busy_load, 0);
    check("rst imem_addr", imem_addr, 0);
    #11;
    rst_n = 1; load_start = 1;
    #1;
    check("post-release busy_load", busy_load, 0);
    load_start = 0;
    @(negedge clk);

    // Three-word load
    q = '{16'h0050, 16'h08D2, 16'h0BD4};
    load_words(q, 1);
    check("load mem0", env_mem[0], 16'h0050);
    check("load mem1", env_mem[1], 16'h08D2);
    check("load mem2", env_mem[2], 16'h0BD4);
    check("load mem3 untouched", env_mem[3], 16'h0000);
    check("load done busy_load", busy_load, 0);

    // load_start wins over run; run ignored inside LOAD
    load_start = 1; run = 1; cyc();
    check("start+run busy_load", busy_load, 1);
    load_start = 0; cyc();
    check("run ignored in LOAD", busy_load, 1);
    run = 0;
    q = '{16'h0050, 16'h08D2, 16'hF000};
    foreach (q[i]) begin
      load_valid = 1; load_data = q[i]; load_last = (i == 2); cyc();
    end
    zero_in(); cyc();

    // Run to halt opcode
    run = 1; cyc(); run = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("run if_pc", if_pc, k);
      check("run if_valid", if_valid, 1);
    end
    check("halt halted", halted, 1);
    check("halt instr_count", instr_count, 3);
    cyc();
    check("halt bubble", if_valid, 0);

    // Redirect at pc 11
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(16'h1000 + 16'(i));
    load_words(q, 1);
    run = 1; cyc(); run = 0;
    for (int k = 0; k < 11; k++) cyc();
    check("pre-redirect if_pc", if_pc, 10);
    redirect_valid = 1; redirect_pc = 8'd15; cyc();
    check("redirect bubble", if_valid, 0);
    redirect_valid = 0; cyc();
    check("redirect if_pc", if_pc, 15);
    check("redirect if_instr", if_instr, 16'h100F);

    // Stall at pc 5, then stall+redirect
    redirect_valid = 1; redirect_pc = 0; cyc(); redirect_valid = 0;
    for (int k = 0; k < 5; k++) cyc();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("stall if_pc", if_pc, 4);
      check("stall instr_count", instr_count, 17);
    end
    redirect_valid = 1; redirect_pc = 2; cyc();
    check("stall+redirect bubble", if_valid, 0);
    stall = 0; redirect_valid = 0; cyc();
    check("stall+redirect if_pc", if_pc, 2);
    check("stall+redirect count", instr_count, 18);

    // Long run: pc wrap and instr_count saturation
    for (int k = 1; k <= 65540; k++) begin
      cyc();
      if (k == 253) check("wrap if_pc 255", if_pc, 255);
      if (k == 254) check("wrap if_pc 0", if_pc, 0);
    end
    check("saturated count", instr_count, 16'hFFFF);

    // Async reset mid-load at load_addr 7
    async_reset();
    load_start = 1; cyc(); load_start = 0;
    for (int i = 0; i < 7; i++) begin
      load_valid = 1; load_data = 16'h2000 + 16'(i); cyc();
    end
    load_data = 16'hABCD;
    #1;
    check("pre-reset imem_we", imem_we, 1);
    check("pre-reset imem_addr", imem_addr, 7);
    rst_n = 0;
    #1;
    check("reset imem_we", imem_we, 0);
    check("reset busy_load", busy_load, 0);
    check("reset load_ready", load_ready, 0);
    check("reset instr_count", instr_count, 0);
    check("reset if_pc", if_pc, 0);
    check("reset if_instr", if_instr, 0);
    model_reset();
    zero_in();
    @(negedge clk);
    rst_n = 1;
    check("reset no write", env_mem[7], 16'h1007);
    check("reset kept mem6", env_mem[6], 16'h2006);

    // 256-word load without load_last, then fetch wrap
    q.delete();
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h0;
      q.push_back(w);
    end
    load_words(q, 0);
    check("full load busy_load", busy_load, 0);
    check("full load mem255", env_mem[255], q[255]);
    check("full load mem0", env_mem[0], q[0]);
    run = 1; cyc(); run = 0;
    for (int k = 0; k < 256; k++) cyc();
    check("full run if_pc 255", if_pc, 255);
    cyc();
    check("full run if_pc 0", if_pc, 0);
    check("full run if_instr", if_instr, q[0]);

    // Random traffic with occasional resets
    async_reset();
    for (int c = 0; c < 4000; c++) begin
      load_start     = ($urandom_range(0, 7) == 0);
      load_valid     = ($urandom_range(0, 1) == 0);
      load_data      = 16'($urandom);
      load_last      = ($urandom_range(0, 7) == 0);
      run            = ($urandom_range(0, 5) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = 8'($urandom);
      if (c % 1000 == 999) async_reset();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
